// File: rtl/gym_spin_controller.sv
// Spinner-tile movement sequencer: takes over the character on a spin tile, slides it to the
// gym-logic stop position one step per frame, settles, then releases. Optional macro GYM_SPIN_ROTATE_EN.
module gym_spin_controller #(
    parameter int STEP_PX       = 2,
    parameter int SETTLE_FRAMES = 4,
    parameter int ROT_FRAMES    = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [9:0] char_x,
    input  logic [9:0] char_y,
    input  logic       player_moving,
    input  logic       atTile,
    input  logic [1:0] spin_direction,
    input  logic [9:0] xleft_next_out,
    input  logic [9:0] ytop_next_out,
    output logic       spin_active,
    output logic [9:0] spin_x,
    output logic [9:0] spin_y,
    output logic [1:0] facing,
    output logic       input_lock,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_SLIDE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [9:0] STEP       = 10'(STEP_PX);
    localparam logic [7:0] SETTLE_END = 8'(SETTLE_FRAMES - 1);

    logic [2:0] r_state;
    logic       r_armed;
    logic       r_active;
    logic [1:0] r_dir;
    logic [1:0] r_facing;
    logic [9:0] r_pos_x;
    logic [9:0] r_pos_y;
    logic [9:0] r_tgt_x;
    logic [9:0] r_tgt_y;
    logic [7:0] r_settle_cnt;

    logic       w_vert;
    logic [9:0] w_tgt_x;
    logic [9:0] w_tgt_y;
    logic       w_tgt_ok;
    logic [9:0] w_dist;
    logic       w_snap;
    logic [9:0] w_step_x;
    logic [9:0] w_step_y;
    logic       w_trigger;

    // Up/down slides keep x; left/right slides keep y.
    assign w_vert  = ~spin_direction[1];
    assign w_tgt_x = w_vert ? char_x : xleft_next_out;
    assign w_tgt_y = w_vert ? ytop_next_out : char_y;

    always_comb begin
        w_tgt_ok = 1'b0;
        case (spin_direction)
            DIR_DOWN:  w_tgt_ok = (w_tgt_y > char_y);
            DIR_UP:    w_tgt_ok = (w_tgt_y < char_y);
            DIR_LEFT:  w_tgt_ok = (w_tgt_x < char_x);
            DIR_RIGHT: w_tgt_ok = (w_tgt_x > char_x);
            default:   w_tgt_ok = 1'b0;
        endcase
    end

    // Remaining distance is never negative: the slide snaps before crossing the target.
    always_comb begin
        w_dist   = 10'd0;
        w_step_x = r_pos_x;
        w_step_y = r_pos_y;
        case (r_dir)
            DIR_DOWN: begin
                w_dist   = r_tgt_y - r_pos_y;
                w_step_y = r_pos_y + STEP;
            end
            DIR_UP: begin
                w_dist   = r_pos_y - r_tgt_y;
                w_step_y = r_pos_y - STEP;
            end
            DIR_LEFT: begin
                w_dist   = r_pos_x - r_tgt_x;
                w_step_x = r_pos_x - STEP;
            end
            default: begin
                w_dist   = r_tgt_x - r_pos_x;
                w_step_x = r_pos_x + STEP;
            end
        endcase
    end

    assign w_snap    = (w_dist <= STEP);
    assign w_trigger = atTile && !player_moving && r_armed;

`ifdef GYM_SPIN_ROTATE_EN
    localparam logic [7:0] ROT_END = 8'(ROT_FRAMES - 1);

    logic [7:0] r_rot_cnt;
    logic [1:0] w_face_next;

    // Rotation order is down -> left -> up -> right -> down.
    always_comb begin
        w_face_next = DIR_DOWN;
        case (r_facing)
            DIR_DOWN:  w_face_next = DIR_LEFT;
            DIR_LEFT:  w_face_next = DIR_UP;
            DIR_UP:    w_face_next = DIR_RIGHT;
            default:   w_face_next = DIR_DOWN;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rot_cnt <= 8'd0;
        end else if (r_state == S_LATCH) begin
            r_rot_cnt <= 8'd0;
        end else if (r_state == S_SLIDE && frame_tick && !w_snap) begin
            r_rot_cnt <= (r_rot_cnt == ROT_END) ? 8'd0 : r_rot_cnt + 8'd1;
        end
    end
`else
    logic [31:0] w_unused_rot;
    assign w_unused_rot = 32'(ROT_FRAMES);
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b1;
            r_active     <= 1'b0;
            r_dir        <= DIR_DOWN;
            r_facing     <= DIR_DOWN;
            r_pos_x      <= 10'd0;
            r_pos_y      <= 10'd0;
            r_tgt_x      <= 10'd0;
            r_tgt_y      <= 10'd0;
            r_settle_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!atTile) begin
                        r_armed <= 1'b1;
                    end
                    if (w_trigger) begin
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_dir        <= spin_direction;
                    r_facing     <= spin_direction;
                    r_active     <= 1'b1;
                    r_pos_x      <= char_x;
                    r_pos_y      <= char_y;
                    r_settle_cnt <= 8'd0;
                    if (w_tgt_ok) begin
                        r_tgt_x <= w_tgt_x;
                        r_tgt_y <= w_tgt_y;
                        r_state <= S_SLIDE;
                    end else begin
                        r_tgt_x <= char_x;
                        r_tgt_y <= char_y;
                        r_state <= S_SETTLE;
                    end
                end
                S_SLIDE: begin
                    if (frame_tick) begin
                        if (w_snap) begin
                            r_pos_x  <= r_tgt_x;
                            r_pos_y  <= r_tgt_y;
                            r_facing <= r_dir;
                            r_state  <= S_SETTLE;
                        end else begin
                            r_pos_x <= w_step_x;
                            r_pos_y <= w_step_y;
`ifdef GYM_SPIN_ROTATE_EN
                            if (r_rot_cnt == ROT_END) begin
                                r_facing <= w_face_next;
                            end
`endif
                        end
                    end
                end
                S_SETTLE: begin
                    if (frame_tick) begin
                        if (r_settle_cnt == SETTLE_END) begin
                            r_state <= S_DONE;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_armed  <= 1'b0;
                    r_active <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign spin_active = r_active;
    assign input_lock  = r_active;
    assign spin_x      = r_pos_x;
    assign spin_y      = r_pos_y;
    assign facing      = r_facing;
    assign done        = (r_state == S_DONE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_gym_spin_controller.sv
// Randomized bench for gym_spin_controller: a per-tick trajectory model fills an expected queue
// and every frame tick of every spin is compared against it.
module tb_gym_spin_controller;

  localparam int STEP   = 2;
  localparam int SETTLE = 4;
  localparam int ROT    = 3;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic [9:0] char_x;
  logic [9:0] char_y;
  logic       player_moving;
  logic       atTile;
  logic [1:0] spin_direction;
  logic [9:0] xleft_next_out;
  logic [9:0] ytop_next_out;
  logic       spin_active;
  logic [9:0] spin_x;
  logic [9:0] spin_y;
  logic [1:0] facing;
  logic       input_lock;
  logic       done;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  // Entries are {facing, y, x} expected after each frame tick of the slide.
  logic [21:0] exp_q[$];

  gym_spin_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .char_x(char_x), .char_y(char_y), .player_moving(player_moving),
    .atTile(atTile), .spin_direction(spin_direction),
    .xleft_next_out(xleft_next_out), .ytop_next_out(ytop_next_out),
    .spin_active(spin_active), .spin_x(spin_x), .spin_y(spin_y),
    .facing(facing), .input_lock(input_lock), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    repeat ($urandom_range(0, 2)) step_clk();
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
  endtask

  function automatic int rot_face(input int dir, input int k);
    int ord[4];
    int idx;
    ord = '{0, 2, 1, 3};
    idx = 0;
    for (int i = 0; i < 4; i++) if (ord[i] == dir) idx = i;
    return ord[(idx + k / ROT) % 4];
  endfunction

  // Reference: target per direction rules, then plain stepping until the target is reached.
  task automatic build_expected(input int px, input int py, input int dir, input int nx, input int ny);
    int tx, ty, cur, tgt, k, face, d;
    bit vert, ok;
    vert = (dir < 2);
    tx = vert ? px : nx;
    ty = vert ? ny : py;
    case (dir)
      0: ok = (ty > py);
      1: ok = (ty < py);
      2: ok = (tx < px);
      default: ok = (tx > px);
    endcase
    if (!ok) return;
    cur = vert ? py : px;
    tgt = vert ? ty : tx;
    k = 0;
    while (cur != tgt) begin
      k++;
      d = (tgt > cur) ? tgt - cur : cur - tgt;
      if (d <= STEP) cur = tgt;
      else cur = (tgt > cur) ? cur + STEP : cur - STEP;
      face = dir;
`ifdef GYM_SPIN_ROTATE_EN
      if (cur != tgt) face = rot_face(dir, k);
`endif
      if (vert) exp_q.push_back({2'(face), 10'(cur), 10'(px)});
      else      exp_q.push_back({2'(face), 10'(py), 10'(cur)});
    end
  endtask

  // driver: one complete spin from trigger to release
  task automatic run_spin(input int px, input int py, input int dir, input int nx, input int ny,
                          input bit do_arm);
    logic [21:0] e;
    logic [9:0]  fin_x, fin_y;
    exp_q.delete();
    build_expected(px, py, dir, nx, ny);
    if (do_arm) begin
      atTile = 1'b0;
      step_clk();
    end
    char_x = 10'(px); char_y = 10'(py);
    spin_direction = 2'(dir);
    xleft_next_out = 10'(nx); ytop_next_out = 10'(ny);
    player_moving = 1'b0;
    atTile = 1'b1;
    step_clk();
    check_eq("latch_not_active", spin_active, 0);
    step_clk();
    check_eq("active_rise", spin_active, 1);
    check_eq("lock_rise", input_lock, 1);
    check_eq("start_x", spin_x, px);
    check_eq("start_y", spin_y, py);
    check_eq("start_facing", facing, dir);
    atTile = 1'($urandom_range(0, 1));
    spin_direction = 2'($urandom);
    xleft_next_out = 10'($urandom); ytop_next_out = 10'($urandom);
    char_x = 10'($urandom); char_y = 10'($urandom);
    fin_x = 10'(px); fin_y = 10'(py);
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check_eq("slide_x", spin_x, e[9:0]);
      check_eq("slide_y", spin_y, e[19:10]);
      check_eq("slide_facing", facing, e[21:20]);
      check_eq("slide_done_low", done, 0);
      fin_x = e[9:0]; fin_y = e[19:10];
    end
    atTile = 1'b1;
    for (int i = 1; i <= SETTLE; i++) begin
      tick();
      check_eq("settle_x", spin_x, fin_x);
      check_eq("settle_y", spin_y, fin_y);
      check_eq("settle_facing", facing, dir);
      check_eq("settle_done", done, (i == SETTLE) ? 1 : 0);
      check_eq("settle_active", spin_active, 1);
    end
    step_clk();
    check_eq("post_done_low", done, 0);
    check_eq("post_active_low", spin_active, 0);
    check_eq("post_lock_low", input_lock, 0);
    check_eq("post_hold_x", spin_x, fin_x);
    check_eq("post_hold_y", spin_y, fin_y);
  endtask

  initial begin
    int px, py;
    Reset = 1'b1;
    frame_tick = 1'b0;
    char_x = '0; char_y = '0;
    player_moving = 1'b0; atTile = 1'b0;
    spin_direction = '0; xleft_next_out = '0; ytop_next_out = '0;
    step_clk();
    step_clk();
    check_eq("rst_active", spin_active, 0);
    check_eq("rst_lock", input_lock, 0);
    check_eq("rst_x", spin_x, 0);
    check_eq("rst_y", spin_y, 0);
    check_eq("rst_facing", facing, 0);
    check_eq("rst_done", done, 0);
    Reset = 1'b0;

    // player-driven move blocks the trigger
    char_x = 10'd100; char_y = 10'd100; spin_direction = 2'd3;
    xleft_next_out = 10'd200; ytop_next_out = 10'd100;
    player_moving = 1'b1; atTile = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      check_eq("player_moving_block", spin_active, 0);
    end
    player_moving = 1'b0;

    // reset in the middle of a slide, then a fresh spin right after release
    atTile = 1'b0;
    step_clk();
    char_x = 10'd448; char_y = 10'd368; spin_direction = 2'd3;
    xleft_next_out = 10'd544; ytop_next_out = 10'd368; atTile = 1'b1;
    step_clk();
    step_clk();
    check_eq("pre_reset_active", spin_active, 1);
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre_reset_x", spin_x, 458);
    Reset = 1'b1;
    #1;
    check_eq("midrst_active", spin_active, 0);
    check_eq("midrst_lock", input_lock, 0);
    check_eq("midrst_x", spin_x, 0);
    check_eq("midrst_y", spin_y, 0);
    check_eq("midrst_facing", facing, 0);
    check_eq("midrst_done", done, 0);
    step_clk();
    step_clk();
    Reset = 1'b0;
    run_spin(448, 368, 3, 544, 368, 1'b0);

    run_spin(0, 64, 1, 0, 15, 1'b1);
    run_spin(448, 368, 2, 500, 368, 1'b1);

    // no re-trigger while atTile stays high after release
    atTile = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      check_eq("no_retrigger", spin_active, 0);
    end
    run_spin(300, 200, 0, 123, 260, 1'b1);

    for (int n = 0; n < 20; n++) begin
      px = $urandom_range(64, 959);
      py = $urandom_range(64, 959);
      run_spin(px, py, $urandom_range(0, 3),
               px + $urandom_range(0, 120) - 60, py + $urandom_range(0, 120) - 60, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
